cpumc_arbiter: RTL and testbench

- Parametrised multi-master arbiter for the CPU memory bus (cpumc).
- Generalises the existing fixed two-way select between rp2a03 and the debug interface to NUM_MASTERS requesters (CPU, HCI debug, a future DMA engine).
- Adds fixed-priority or round-robin arbitration, a request/ack handshake, registered bus drive and a bus-lock mode for debug halt.
- Sits between the masters and the shared slave bus (cart PRG, WRAM, PPU register interface). Slave read data arrives OR-combined.

---
 rtl/cpumc_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cpumc_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpumc_arbiter.sv
// Multi-master arbiter for the CPU memory bus: fixed-priority or round-robin
// grant, registered bus drive, one-cycle ack and a bus-lock mode for debug halt.

module cpumc_arb_lane #(
  parameter int             IW  = 1,
  parameter logic [IW-1:0]  IDX = '0
) (
  input  logic          i_req,
  input  logic          i_locked,
  input  logic          i_lock_vld,
  input  logic [IW-1:0] i_lock_own,
  input  logic          i_in_data,
  input  logic [IW-1:0] i_owner,
  output logic          o_elig,
  output logic          o_rdy
);
  // While locked only the lock owner competes; otherwise the owner whose
  // transaction is being acked sits out the DATA arbitration.
  always_comb begin
    o_elig = 1'b0;
    if (i_req) begin
      if (i_locked) o_elig = (i_lock_own == IDX);
      else          o_elig = !(i_in_data && (i_owner == IDX));
    end
  end

  assign o_rdy = !(i_lock_vld && (i_lock_own != IDX));
endmodule

module cpumc_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int RR_MODE     = 0
) (
  input  logic                              clk_in,
  input  logic                              nrst_in,
  input  logic [NUM_MASTERS-1:0]            req_in,
  input  logic [NUM_MASTERS-1:0]            lock_in,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in,
  input  logic [NUM_MASTERS-1:0]            m_r_nw_in,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_d_in,
  input  logic [DATA_WIDTH-1:0]             bus_d_in,
  output logic [ADDR_WIDTH-1:0]             bus_a_out,
  output logic                              bus_r_nw_out,
  output logic [DATA_WIDTH-1:0]             bus_d_out,
  output logic [NUM_MASTERS-1:0]            gnt_out,
  output logic [NUM_MASTERS-1:0]            ack_out,
  output logic [DATA_WIDTH-1:0]             rd_out,
  output logic [NUM_MASTERS-1:0]            rdy_out,
  output logic                              busy_out
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] a;
    logic                  r_nw;
    logic [DATA_WIDTH-1:0] d;
  } mreq_t;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                 r_state, w_state_nxt;
  mreq_t                  r_bus;
  logic [NUM_MASTERS-1:0] r_gnt, r_ack;
  logic [DATA_WIDTH-1:0]  r_rd;
  logic [IW-1:0]          r_owner, r_lock_own, r_ptr;
  logic                   r_lock_vld;

  mreq_t                  w_mreq [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] w_elig, w_rdy, w_win_oh;
  logic [IW-1:0]          w_win, w_idx, w_base, w_ptr_nxt;
  logic                   w_win_vld, w_arb_pt, w_locked, w_grant;

  assign w_arb_pt = (r_state == S_IDLE) || (r_state == S_DATA);
  assign w_locked = r_lock_vld && lock_in[r_lock_own];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_lane
    assign w_mreq[g] = {m_a_in[g*ADDR_WIDTH +: ADDR_WIDTH], m_r_nw_in[g],
                        m_d_in[g*DATA_WIDTH +: DATA_WIDTH]};
    cpumc_arb_lane #(.IW(IW), .IDX(IW'(g))) u_lane (
      .i_req      (req_in[g]),
      .i_locked   (w_locked),
      .i_lock_vld (r_lock_vld),
      .i_lock_own (r_lock_own),
      .i_in_data  (r_state == S_DATA),
      .i_owner    (r_owner),
      .o_elig     (w_elig[g]),
      .o_rdy      (w_rdy[g])
    );
  end

  // Search starts at the RR pointer (or 0 in fixed mode); scanning offsets
  // downwards lets the smallest offset overwrite the result last.
  assign w_base = (RR_MODE != 0) ? r_ptr : '0;

  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      w_idx = IW'((int'(w_base) + i) % NUM_MASTERS);
      if (w_elig[w_idx]) begin
        w_win_vld = 1'b1;
        w_win     = w_idx;
      end
    end
  end

  assign w_grant   = w_arb_pt && w_win_vld;
  assign w_win_oh  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_nxt = (w_win == IW'(NUM_MASTERS - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_win_vld) w_state_nxt = S_ADDR;
      S_ADDR:  w_state_nxt = S_DATA;
      S_DATA:  w_state_nxt = w_win_vld ? S_ADDR : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_state    <= S_IDLE;
      r_bus      <= '{a: '0, r_nw: 1'b1, d: '0};
      r_gnt      <= '0;
      r_ack      <= '0;
      r_rd       <= '0;
      r_owner    <= '0;
      r_lock_own <= '0;
      r_lock_vld <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= '0;
      if (r_state == S_ADDR) begin
        r_ack <= r_gnt;
        r_rd  <= bus_d_in;
      end
      if (w_grant) begin
        r_bus      <= w_mreq[w_win];
        r_gnt      <= w_win_oh;
        r_owner    <= w_win;
        r_lock_vld <= lock_in[w_win];
        r_lock_own <= w_win;
        r_ptr      <= w_ptr_nxt;
      end else if (w_arb_pt) begin
        // Park the bus in a harmless read; the address is left as it was.
        r_bus.r_nw <= 1'b1;
        r_bus.d    <= '0;
        r_gnt      <= '0;
        if (!w_locked) r_lock_vld <= 1'b0;
      end
    end
  end

  assign bus_a_out    = r_bus.a;
  assign bus_r_nw_out = r_bus.r_nw;
  assign bus_d_out    = r_bus.d;
  assign gnt_out      = r_gnt;
  assign ack_out      = r_ack;
  assign rd_out       = r_rd;
  assign rdy_out      = w_rdy;
  assign busy_out     = (r_state != S_IDLE);
endmodule

// File: tb/tb_cpumc_arbiter.sv
// Bench for cpumc_arbiter: fixed-priority and round-robin instances, each with
// its own slave memory, checked every cycle against a transaction-level model.

module tb_cpumc_arbiter;
  localparam int N = 3, AW = 16, DW = 8;

  logic clk = 1'b0, nrst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0, lock = '0, rnw = '1;
  logic [N*AW-1:0] ma = '0;
  logic [N*DW-1:0] md = '0;

  logic [1:0][N-1:0]  gnt, ack, rdy;
  logic [1:0][AW-1:0] ba;
  logic [1:0][DW-1:0] bd, rd, bdi;
  logic [1:0]         brnw, busy;

  int n_pass = 0, n_total = 0;
  bit chk_on = 1'b0;

  cpumc_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) u_fp (
    .clk_in(clk), .nrst_in(nrst), .req_in(req), .lock_in(lock), .m_a_in(ma),
    .m_r_nw_in(rnw), .m_d_in(md), .bus_d_in(bdi[0]), .bus_a_out(ba[0]),
    .bus_r_nw_out(brnw[0]), .bus_d_out(bd[0]), .gnt_out(gnt[0]), .ack_out(ack[0]),
    .rd_out(rd[0]), .rdy_out(rdy[0]), .busy_out(busy[0]));

  cpumc_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) u_rr (
    .clk_in(clk), .nrst_in(nrst), .req_in(req), .lock_in(lock), .m_a_in(ma),
    .m_r_nw_in(rnw), .m_d_in(md), .bus_d_in(bdi[1]), .bus_a_out(ba[1]),
    .bus_r_nw_out(brnw[1]), .bus_d_out(bd[1]), .gnt_out(gnt[1]), .ack_out(ack[1]),
    .rd_out(rd[1]), .rdy_out(rdy[1]), .busy_out(busy[1]));

  // Unwritten memory locations read a fixed pattern; location 3 holds 8'h5A.
  function automatic logic [7:0] finit(input logic [3:0] i);
    logic [7:0] t;
    t = {4'h0, i};
    return 8'h27 + t * 8'h11;
  endfunction

  // Slave: 16-entry memory per instance, write commits at the end of ADDR.
  logic [7:0]  smem [2][16];
  logic [15:0] swr  [2] = '{16'h0, 16'h0};

  always_comb
    for (int k = 0; k < 2; k++)
      bdi[k] = brnw[k] ? (swr[k][ba[k][3:0]] ? smem[k][ba[k][3:0]] : finit(ba[k][3:0])) : 8'h00;

  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (busy[k] && ack[k] == '0 && !brnw[k]) begin
        smem[k][ba[k][3:0]] <= bd[k];
        swr[k][ba[k][3:0]]  <= 1'b1;
      end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model (per instance, k=0 fixed, k=1 RR) ----------
  int          ph [2], own [2], lko [2], ptr [2];
  bit          lkv [2];
  logic [N-1:0]  mg [2], mk [2];
  logic [AW-1:0] mba [2];
  logic          mrnw [2];
  logic [DW-1:0] mbd [2], mrd [2];
  logic [7:0]    mmem [2][16];
  logic [15:0]   mwr [2];

  task automatic mreset(input int k);
    ph[k] = 0; own[k] = 0; lko[k] = 0; ptr[k] = 0; lkv[k] = 0;
    mg[k] = '0; mk[k] = '0; mba[k] = '0; mrnw[k] = 1'b1; mbd[k] = '0; mrd[k] = '0;
  endtask

  task automatic mstep(input int k);
    bit locked;
    int w;
    logic [3:0] a;
    locked = lkv[k] && lock[lko[k]];
    w = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (k == 1) ? (ptr[k] + i) % N : i;
      if (w < 0 && req[j] && (locked ? (j == lko[k]) : !(ph[k] == 2 && j == own[k]))) w = j;
    end
    if (ph[k] == 1) begin
      a = mba[k][3:0];
      if (mrnw[k]) mrd[k] = mwr[k][a] ? mmem[k][a] : finit(a);
      else begin
        mrd[k] = 8'h00;
        mmem[k][a] = mbd[k];
        mwr[k][a] = 1'b1;
      end
      mk[k] = mg[k];
      ph[k] = 2;
    end else begin
      mk[k] = '0;
      if (w >= 0) begin
        ph[k] = 1; own[k] = w; mg[k] = N'(1) << w;
        mba[k] = ma[w*AW +: AW]; mrnw[k] = rnw[w]; mbd[k] = md[w*DW +: DW];
        lkv[k] = lock[w]; lko[k] = w; ptr[k] = (w + 1) % N;
      end else begin
        ph[k] = 0; mg[k] = '0; mrnw[k] = 1'b1; mbd[k] = '0;
        if (!locked) lkv[k] = 1'b0;
      end
    end
  endtask

  function automatic logic [N-1:0] mrdy(input int k);
    return lkv[k] ? (N'(1) << lko[k]) : '1;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      mreset(k);
      mwr[k] = 16'h0;
    end
    forever begin
      @(posedge clk or negedge nrst);
      for (int k = 0; k < 2; k++)
        if (!nrst) mreset(k);
        else mstep(k);
    end
  end

  // Every-cycle comparison, 1 time unit after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_on)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("k%0d gnt", k),  gnt[k],  mg[k]);
        chk($sformatf("k%0d ack", k),  ack[k],  mk[k]);
        chk($sformatf("k%0d rd", k),   rd[k],   mrd[k]);
        chk($sformatf("k%0d bus_a", k), ba[k],  mba[k]);
        chk($sformatf("k%0d r_nw", k), brnw[k], mrnw[k]);
        chk($sformatf("k%0d bus_d", k), bd[k],  mbd[k]);
        chk($sformatf("k%0d rdy", k),  rdy[k],  mrdy(k));
        chk($sformatf("k%0d busy", k), busy[k], ph[k] != 0);
      end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; lock = '0; rnw = '1;
    nrst = 1'b0;
    repeat (2) tick();
    nrst = 1'b1;
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, " gnt"}, gnt[k], 3'b000);
      chk({nm, " ack"}, ack[k], 3'b000);
      chk({nm, " bus_a"}, ba[k], 16'h0000);
      chk({nm, " r_nw"}, brnw[k], 1'b1);
      chk({nm, " rdy"}, rdy[k], 3'b111);
      chk({nm, " busy"}, busy[k], 1'b0);
    end
  endtask

  initial begin
    int cnt, found;
    logic [N-1:0] seen [$];
    int when [$];

    tick();
    do_reset();
    chk_on = 1'b1;
    chk_reset_vals("reset");
    chk("reset rd", rd[0], 8'h00);
    chk("reset bus_d", bd[0], 8'h00);

    // Single read of 0x0123 (slave location 3 = 5A)
    ma[0*AW +: AW] = 16'h0123; rnw = 3'b111; req = 3'b001;
    tick();
    chk("rd1 bus_a", ba[0], 16'h0123);
    chk("rd1 gnt", gnt[0], 3'b001);
    req = '0;
    tick();
    chk("rd1 ack", ack[0], 3'b001);
    chk("rd1 rd", rd[0], 8'h5A);
    chk("rd1 model ack", mk[0], 3'b001);
    chk("rd1 model rd", mrd[0], 8'h5A);
    tick();
    chk("rd1 idle busy", busy[0], 1'b0);
    chk("rd1 idle r_nw", brnw[0], 1'b1);

    // Fixed priority: m0 and m1 together
    ma[1*AW +: AW] = 16'h0042; req = 3'b011;
    tick();
    chk("fp gnt0", gnt[0], 3'b001);
    tick();
    chk("fp ack0", ack[0], 3'b001);
    req = 3'b010;
    tick();
    chk("fp gnt1", gnt[0], 3'b010);
    tick();
    chk("fp ack1", ack[0], 3'b010);
    req = '0;
    tick();

    // Round robin with all masters requesting continuously
    do_reset();
    req = 3'b111;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack[1] != '0) begin
        seen.push_back(ack[1]);
        when.push_back(c);
      end
    end
    chk("rr ack count", seen.size(), 6);
    for (int n = 0; n < 6 && n < seen.size(); n++) begin
      chk($sformatf("rr ack order %0d", n), seen[n], N'(1) << (n % 3));
      chk($sformatf("rr ack cycle %0d", n), when[n], 2 * (n + 1));
    end
    req = '0;
    repeat (2) tick();

    // Lock: m1 locks while m0 keeps requesting
    do_reset();
    req = 3'b011; lock = 3'b010;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (gnt[0] == 3'b010) found = 1;
    end
    chk("lock first grant", found, 1);
    chk("lock rdy", rdy[0], 3'b010);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (gnt[0][0]) cnt++;
    end
    chk("lock m0 blocked", cnt, 0);
    chk("lock rdy held", rdy[0], 3'b010);
    found = 0;
    for (int c = 0; c < 4 && !found; c++) begin
      if (ack[0] == 3'b010) found = 1;
      else tick();
    end
    chk("lock ack seen", found, 1);
    lock = '0;
    tick();
    chk("unlock gnt m0", gnt[0], 3'b001);
    chk("unlock rdy", rdy[0], 3'b111);
    req = '0;
    repeat (3) tick();

    // Write A7 to 0x0005 from m1, then read it back via m0
    do_reset();
    ma[1*AW +: AW] = 16'h0005; md[1*DW +: DW] = 8'hA7; rnw = 3'b101; req = 3'b010;
    tick();
    chk("wr r_nw", brnw[0], 1'b0);
    chk("wr bus_d", bd[0], 8'hA7);
    chk("wr bus_a", ba[0], 16'h0005);
    req = '0;
    tick();
    chk("wr ack", ack[0], 3'b010);
    tick();
    chk("wr idle r_nw", brnw[0], 1'b1);
    chk("wr idle bus_d", bd[0], 8'h00);
    ma[0*AW +: AW] = 16'h0005; rnw = 3'b111; req = 3'b001;
    tick();
    req = '0;
    tick();
    chk("wr readback ack", ack[0], 3'b001);
    chk("wr readback rd", rd[0], 8'hA7);
    tick();

    // Reset during ADDR
    ma[0*AW +: AW] = 16'h0123; req = 3'b001;
    tick();
    chk("rst pre busy", busy[0], 1'b1);
    nrst = 1'b0;
    #1;
    chk_reset_vals("rst async");
    tick();
    chk("rst no ack", ack[0], 3'b000);
    nrst = 1'b1;
    tick();
    chk("rst regrant", gnt[0], 3'b001);
    chk("rst regrant a", ba[0], 16'h0123);
    req = '0;
    tick();
    chk("rst reack", ack[0], 3'b001);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      req  = N'($urandom);
      lock = N'($urandom & $urandom & $urandom);
      rnw  = N'($urandom);
      for (int m = 0; m < N; m++) begin
        ma[m*AW +: AW] = AW'($urandom);
        md[m*DW +: DW] = DW'($urandom);
      end
      if ($urandom_range(399, 0) == 0) begin
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
      end
    end
    req = '0; lock = '0;
    repeat (4) tick();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
